// File: rtl/nios2_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between JTAG strobes and the Avalon debug slave.
// Latency: JTAG ops issue same cycle, read data lands in MonDReg next cycle; Avalon write 2 / read 3 cycles.
// Backpressure: JTAG always wins a cycle; Avalon is held off with waitrequest and retries.
module nios2_ocimem_arbiter #(
   parameter int AW = 8
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic [37:0]   jdo,
   input  logic          take_action_ocimem_a,
   input  logic          take_action_ocimem_b,
   input  logic          take_no_action_ocimem_a,
   input  logic [AW-1:0] avalon_address,
   input  logic          avalon_read,
   input  logic          avalon_write,
   input  logic [31:0]   avalon_writedata,
   input  logic [3:0]    avalon_byteenable,
   input  logic          debugaccess,
   output logic [31:0]   avalon_readdata,
   output logic          avalon_waitrequest,
   output logic [AW-1:0] ram_addr,
   output logic [31:0]   ram_wrdata,
   output logic [3:0]    ram_byteenable,
   output logic          ram_wren,
   output logic          ram_rden,
   input  logic [31:0]   ram_rddata,
   output logic [AW-1:0] MonAReg,
   output logic [31:0]   MonDReg
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RD   = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic          jtag_rd_pend;
   logic          av_rd_pend;
   logic          jt_b;
   logic          jt_a;
   logic          jt_na;
   logic          jt_any;
   logic          jt_rd;
   logic          av_req;
   logic          av_issue;
   logic          wren_c;
   logic          rden_c;
   logic [AW-1:0] jt_addr_fld;
   logic [AW-1:0] mon_a_nxt;
   logic          unused_jdo_bits;

   // One strobe is honoured per cycle: ocimem_b > ocimem_a > no_action_ocimem_a.
   assign jt_b        = take_action_ocimem_b;
   assign jt_a        = take_action_ocimem_a & ~take_action_ocimem_b;
   assign jt_na       = take_no_action_ocimem_a & ~take_action_ocimem_b & ~take_action_ocimem_a;
   assign jt_any      = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
   assign jt_addr_fld = jdo[AW+16:17];
   assign jt_rd       = jt_na | (jt_a & jdo[34]);

   assign av_req   = avalon_read | avalon_write;
   assign av_issue = (state == IDLE) & av_req & ~jt_any;

   assign unused_jdo_bits = ^{jdo[37:35], jdo[2:0]};

   always_comb begin
      ram_addr       = avalon_address;
      ram_wrdata     = avalon_writedata;
      ram_byteenable = avalon_byteenable;
      wren_c         = 1'b0;
      rden_c         = 1'b0;
      mon_a_nxt      = MonAReg;
      if (jt_b) begin
         ram_addr       = MonAReg;
         ram_wrdata     = jdo[34:3];
         ram_byteenable = 4'hF;
         wren_c         = 1'b1;
         mon_a_nxt      = MonAReg + AW'(1);
      end else if (jt_a) begin
         ram_addr  = jt_addr_fld;
         rden_c    = jdo[34];
         mon_a_nxt = jdo[34] ? jt_addr_fld + AW'(1) : jt_addr_fld;
      end else if (jt_na) begin
         ram_addr  = MonAReg;
         rden_c    = 1'b1;
         mon_a_nxt = MonAReg + AW'(1);
      end else if (av_issue) begin
         // Writes without debugaccess still complete the handshake but never touch RAM.
         rden_c = avalon_read;
         wren_c = ~avalon_read & avalon_write & debugaccess;
      end
   end

   assign ram_wren = wren_c & reset_n;
   assign ram_rden = rden_c & reset_n;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (av_issue) begin
               state_nxt = avalon_read ? RD : ACK;
            end
         end
         RD:      state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign avalon_waitrequest = av_req & (state != ACK);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= IDLE;
         jtag_rd_pend    <= 1'b0;
         av_rd_pend      <= 1'b0;
         MonAReg         <= '0;
         MonDReg         <= '0;
         avalon_readdata <= '0;
      end else begin
         state        <= state_nxt;
         jtag_rd_pend <= jt_rd;
         av_rd_pend   <= av_issue & avalon_read;
         MonAReg      <= mon_a_nxt;
         // Only one read issues per cycle, so at most one of these captures.
         if (jtag_rd_pend) begin
            MonDReg <= ram_rddata;
         end
         if (av_rd_pend) begin
            avalon_readdata <= ram_rddata;
         end
      end
   end

endmodule
